// File: rtl/mux_sync_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : mux_sync_tx_arbiter_if
//  Brief    : Requester/arbiter bundle for the mux-synchronizer TX scheduler.
//             The master side is the requester pool. The slave side is the
//             arbiter that drives the synchronizer channel.
//  Revision : 1.0  initial release
// ============================================================================
interface mux_sync_tx_arbiter_if #(
   parameter int NREQ = 4,
   parameter int DW   = 3
);
   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [NREQ-1:0]    req;
   logic [NREQ*DW-1:0] req_data;
   logic [NREQ-1:0]    ack;
   logic               sync_en;
   logic [DW-1:0]      sync_data;
   logic [IW-1:0]      gnt_id;
   logic               busy;
   logic               done;

   // Requester pool: raises requests and observes grants and channel status
   modport master (
      output req, req_data,
      input  ack, sync_en, sync_data, gnt_id, busy, done
   );

   // Arbiter/scheduler: consumes requests and drives the channel
   modport slave (
      input  req, req_data,
      output ack, sync_en, sync_data, gnt_id, busy, done
   );
endinterface
`default_nettype wire

// File: rtl/mux_sync_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mux_sync_tx_arbiter
//  Brief    : Source-side scheduler for one shared mux-synchronizer channel.
//             Round-robin picks a requester, holds its data, then raises
//             the enable one cycle after the data is stable. The enable
//             stays high for HOLD_CYCLES. The data is then held for
//             GAP_CYCLES with the enable low before the next load.
//  Revision : 1.0  initial release
// ============================================================================
module mux_sync_tx_arbiter #(
   parameter int NREQ        = 4,
   parameter int DW          = 3,
   parameter int HOLD_CYCLES = 4,
   parameter int GAP_CYCLES  = 2
) (
   input  wire logic          clk,
   input  wire logic          rst,
   mux_sync_tx_arbiter_if.slave bus
);
   localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CMAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
   localparam int CW   = $clog2(CMAX + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_HOLD = 2'd2,
      S_GAP  = 2'd3
   } state_t;

   state_t          r_state;
   logic [IW-1:0]   r_ptr;
   logic [CW-1:0]   r_cnt;
   logic [NREQ-1:0] r_ack;
   logic            r_sync_en;
   logic [DW-1:0]   r_sync_data;
   logic [IW-1:0]   r_gnt_id;
   logic            r_done;

   logic            w_found;
   logic [IW-1:0]   w_win;

   // Round-robin search: first set request at or after r_ptr, wrapping
   always_comb begin : p_pick
      int v_idx;
      w_found = 1'b0;
      w_win   = '0;
      v_idx   = 0;
      for (int k = 0; k < NREQ; k++) begin
         v_idx = int'(r_ptr) + k;
         if (v_idx >= NREQ) v_idx = v_idx - NREQ;
         if (!w_found && bus.req[v_idx]) begin
            w_found = 1'b1;
            w_win   = IW'(v_idx);
         end
      end
   end

   // Transfer sequencer: IDLE -> LOAD -> HOLD -> GAP -> IDLE, all outputs registered
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_ptr       <= '0;
         r_cnt       <= '0;
         r_ack       <= '0;
         r_sync_en   <= 1'b0;
         r_sync_data <= '0;
         r_gnt_id    <= '0;
         r_done      <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               if (w_found) begin
                  // Only this edge may change the held data
                  r_state     <= S_LOAD;
                  r_sync_data <= bus.req_data[int'(w_win)*DW +: DW];
                  r_gnt_id    <= w_win;
                  r_ack       <= NREQ'(1) << w_win;
                  r_ptr       <= (w_win == IW'(NREQ-1)) ? '0 : w_win + 1'b1;
               end
            end
            S_LOAD: begin
               // Data has had a full cycle to settle; the enable can rise now
               r_ack     <= '0;
               r_state   <= S_HOLD;
               r_cnt     <= '0;
               r_sync_en <= 1'b1;
            end
            S_HOLD: begin
               if (r_cnt == CW'(HOLD_CYCLES-1)) begin
                  r_sync_en <= 1'b0;
                  r_state   <= S_GAP;
                  r_cnt     <= '0;
                  r_done    <= (GAP_CYCLES == 1);
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_GAP: begin
               if (r_cnt == CW'(GAP_CYCLES-1)) begin
                  r_state <= S_IDLE;
                  r_cnt   <= '0;
                  r_done  <= 1'b0;
               end else begin
                  r_cnt  <= r_cnt + 1'b1;
                  // Flag the cycle that will be the last one of the gap
                  r_done <= (GAP_CYCLES >= 2) && (r_cnt == CW'(GAP_CYCLES-2));
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.ack       = r_ack;
   assign bus.sync_en   = r_sync_en;
   assign bus.sync_data = r_sync_data;
   assign bus.gnt_id    = r_gnt_id;
   assign bus.done      = r_done;
   assign bus.busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mux_sync_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mux_sync_tx_arbiter
//  Brief    : Directed self-checking bench for mux_sync_tx_arbiter.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mux_sync_tx_arbiter;
   localparam int NREQ = 4;
   localparam int DW   = 3;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   logic [DW-1:0] dval [NREQ];

   mux_sync_tx_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();

   mux_sync_tx_arbiter #(
      .NREQ(NREQ), .DW(DW), .HOLD_CYCLES(4), .GAP_CYCLES(2)
   ) u_dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one cycle; sample point is 1 ns after the rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_data();
      for (int i = 0; i < NREQ; i++) bus.req_data[i*DW +: DW] = dval[i];
   endtask

   task automatic do_reset();
      bus.req = '0;
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (bus.busy === 1'b1 && n < 30) begin
         tick();
         n++;
      end
      checks++;
      if (bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL %s_idle_timeout busy=%b required=0", name, bus.busy);
      end
   endtask

   task automatic test_reset();
      int bad;
      bus.req = '0;
      load_data();
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      bad = 0;
      for (int c = 0; c < 20; c++) begin
         tick();
         checks++;
         if (bus.sync_en !== 1'b0 || bus.sync_data !== 3'd0 || bus.busy !== 1'b0 ||
             bus.ack !== 4'b0000 || bus.done !== 1'b0 || bus.gnt_id !== 2'd0) begin
            errors++;
            $display("FAIL reset_idle c=%0d en=%b data=%0d busy=%b ack=%b done=%b gnt=%0d required all 0",
                     c, bus.sync_en, bus.sync_data, bus.busy, bus.ack, bus.done, bus.gnt_id);
         end
      end
   endtask

   task automatic test_single_transfer();
      bus.req = 4'b0100;                      // cycle t
      tick();                                 // t+1: LOAD
      checks++;
      if (bus.ack !== 4'b0100 || bus.sync_data !== 3'd5 || bus.gnt_id !== 2'd2 ||
          bus.sync_en !== 1'b0 || bus.busy !== 1'b1) begin
         errors++;
         $display("FAIL single_load ack=%b data=%0d gnt=%0d en=%b busy=%b required ack=0100 data=5 gnt=2 en=0 busy=1",
                  bus.ack, bus.sync_data, bus.gnt_id, bus.sync_en, bus.busy);
      end
      bus.req = '0;
      for (int c = 2; c <= 5; c++) begin
         tick();
         checks++;
         if (bus.sync_en !== 1'b1 || bus.ack !== 4'b0000 || bus.done !== 1'b0 || bus.sync_data !== 3'd5) begin
            errors++;
            $display("FAIL single_hold t+%0d en=%b ack=%b done=%b data=%0d required en=1 ack=0 done=0 data=5",
                     c, bus.sync_en, bus.ack, bus.done, bus.sync_data);
         end
      end
      tick();                                 // t+6: first GAP cycle
      checks++;
      if (bus.sync_en !== 1'b0 || bus.done !== 1'b0 || bus.busy !== 1'b1) begin
         errors++;
         $display("FAIL single_gap1 en=%b done=%b busy=%b required en=0 done=0 busy=1",
                  bus.sync_en, bus.done, bus.busy);
      end
      tick();                                 // t+7: last GAP cycle
      checks++;
      if (bus.done !== 1'b1 || bus.sync_en !== 1'b0 || bus.busy !== 1'b1) begin
         errors++;
         $display("FAIL single_done done=%b en=%b busy=%b required done=1 en=0 busy=1",
                  bus.done, bus.sync_en, bus.busy);
      end
      tick();                                 // t+8: back in IDLE
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.sync_data !== 3'd5) begin
         errors++;
         $display("FAIL single_idle busy=%b done=%b data=%0d required busy=0 done=0 data=5",
                  bus.busy, bus.done, bus.sync_data);
      end
   endtask

   task automatic test_round_robin();
      int exp_order [6];
      int n;
      int last;
      exp_order = '{0, 1, 2, 3, 0, 1};
      do_reset();
      bus.req = 4'b1111;
      last = 0;
      for (int g = 0; g < 6; g++) begin
         n = 0;
         do begin
            tick();
            n++;
         end while (bus.ack === 4'b0000 && n < 20);
         checks++;
         if (bus.ack !== (4'b0001 << exp_order[g]) || bus.gnt_id !== 2'(exp_order[g]) ||
             bus.sync_data !== dval[exp_order[g]]) begin
            errors++;
            $display("FAIL rr_grant%0d ack=%b gnt=%0d data=%0d required ack=%b gnt=%0d data=%0d",
                     g, bus.ack, bus.gnt_id, bus.sync_data, 4'b0001 << exp_order[g],
                     exp_order[g], dval[exp_order[g]]);
         end
         checks++;
         if ((g == 0 && n != 1) || (g > 0 && n != 8)) begin
            errors++;
            $display("FAIL rr_spacing%0d cycles=%0d required=%0d", g, n, (g == 0) ? 1 : 8);
         end
         last = n;
      end
      bus.req = '0;
      wait_idle("rr");
   endtask

   task automatic test_wrap();
      int exp_gnt [3];
      int n;
      exp_gnt = '{3, 0, 1};
      do_reset();
      bus.req = 4'b0001;                      // one grant to requester 0 leaves ptr=1
      tick();
      checks++;
      if (bus.ack !== 4'b0001) begin
         errors++;
         $display("FAIL wrap_setup ack=%b required=0001", bus.ack);
      end
      bus.req = '0;
      wait_idle("wrap_setup");
      bus.req = 4'b1001;
      for (int g = 0; g < 3; g++) begin
         if (g == 2) bus.req = 4'b1111;       // ptr=1 now, so requester 1 must win
         n = 0;
         do begin
            tick();
            n++;
         end while (bus.ack === 4'b0000 && n < 20);
         checks++;
         if (bus.ack !== (4'b0001 << exp_gnt[g]) || bus.gnt_id !== 2'(exp_gnt[g])) begin
            errors++;
            $display("FAIL wrap_grant%0d ack=%b gnt=%0d required gnt=%0d",
                     g, bus.ack, bus.gnt_id, exp_gnt[g]);
         end
      end
      bus.req = '0;
      wait_idle("wrap");
   endtask

   task automatic test_reset_mid_hold();
      do_reset();
      bus.req = 4'b0010;
      tick();                                 // LOAD
      bus.req = '0;
      tick();                                 // HOLD cycle 1
      tick();                                 // HOLD cycle 2
      checks++;
      if (bus.sync_en !== 1'b1) begin
         errors++;
         $display("FAIL midhold_pre en=%b required=1", bus.sync_en);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if (bus.sync_en !== 1'b0 || bus.busy !== 1'b0 || bus.ack !== 4'b0000 ||
          bus.sync_data !== 3'd0 || bus.gnt_id !== 2'd0 || bus.done !== 1'b0) begin
         errors++;
         $display("FAIL midhold_async en=%b busy=%b ack=%b data=%0d gnt=%0d done=%b required all 0",
                  bus.sync_en, bus.busy, bus.ack, bus.sync_data, bus.gnt_id, bus.done);
      end
      repeat (2) tick();
      rst = 1'b0;
      repeat (2) tick();
      checks++;
      if (bus.busy !== 1'b0 || bus.ack !== 4'b0000) begin
         errors++;
         $display("FAIL midhold_nopending busy=%b ack=%b required busy=0 ack=0000", bus.busy, bus.ack);
      end
      bus.req = 4'b0010;
      tick();
      checks++;
      if (bus.ack !== 4'b0010 || bus.gnt_id !== 2'd1 || bus.sync_data !== dval[1] || bus.sync_en !== 1'b0) begin
         errors++;
         $display("FAIL midhold_regrant ack=%b gnt=%0d data=%0d en=%b required ack=0010 gnt=1 data=%0d en=0",
                  bus.ack, bus.gnt_id, bus.sync_data, bus.sync_en, dval[1]);
      end
      bus.req = '0;
      for (int c = 2; c <= 5; c++) begin
         tick();
         checks++;
         if (bus.sync_en !== 1'b1) begin
            errors++;
            $display("FAIL midhold_hold t+%0d en=%b required=1", c, bus.sync_en);
         end
      end
      tick();
      tick();
      checks++;
      if (bus.done !== 1'b1 || bus.sync_en !== 1'b0) begin
         errors++;
         $display("FAIL midhold_done done=%b en=%b required done=1 en=0", bus.done, bus.sync_en);
      end
      tick();
      checks++;
      if (bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL midhold_end busy=%b required=0", bus.busy);
      end
   endtask

   task automatic test_withdrawn_pulse();
      int n;
      bus.req = 4'b0100;                      // requester 2 transfer, data 5
      tick();
      bus.req = '0;
      tick();                                 // HOLD cycle 1
      bus.req_data[1*DW +: DW] = 3'd2;
      bus.req = 4'b0010;                      // one-cycle pulse during HOLD
      tick();
      bus.req = '0;
      bus.req_data[1*DW +: DW] = dval[1];
      for (int c = 0; c < 12; c++) begin
         tick();
         checks++;
         if (bus.ack !== 4'b0000 || bus.sync_data !== 3'd5) begin
            errors++;
            $display("FAIL pulse_ignored c=%0d ack=%b data=%0d required ack=0000 data=5",
                     c, bus.ack, bus.sync_data);
         end
      end
      bus.req = 4'b1000;
      n = 0;
      do begin
         tick();
         n++;
      end while (bus.ack === 4'b0000 && n < 20);
      checks++;
      if (bus.ack !== 4'b1000 || bus.sync_data !== dval[3]) begin
         errors++;
         $display("FAIL pulse_nextload ack=%b data=%0d required ack=1000 data=%0d",
                  bus.ack, bus.sync_data, dval[3]);
      end
      bus.req = '0;
      wait_idle("pulse");
   endtask

   // Watchdog so the run always terminates
   initial begin
      #200000;
      $display("FAIL watchdog_timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      checks = 0;
      errors = 0;
      rst    = 1'b1;
      bus.req = '0;
      bus.req_data = '0;
      dval[0] = 3'd3;
      dval[1] = 3'd6;
      dval[2] = 3'd5;
      dval[3] = 3'd7;
      test_reset();
      test_single_transfer();
      test_round_robin();
      test_wrap();
      test_reset_mid_hold();
      test_withdrawn_pulse();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
